// File: rtl/sdram_init_seq_if.sv
// sdram_init_seq_if: request/ownership handshake between a bus controller and the SDRAM init sequencer
interface sdram_init_seq_if;
  logic ireq, ienb, obusy, ofin;
  modport master(output ireq, ienb, input obusy, ofin);
  modport slave(input ireq, ienb, output obusy, ofin);
endinterface

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: parametrised SDRAM power-up sequencer (CKE, NOP wait, PRECHARGE ALL, N x REFRESH, LOAD MODE)
module sdram_init_seq #(
  parameter int ADDR_W = 13,
  parameter int BA_W = 2,
  parameter int DQ_W = 16,
  parameter int T_POWERUP = 10000,
  parameter int T_RP = 3,
  parameter int T_RFC = 7,
  parameter int T_MRD = 2,
  parameter int REFRESH_COUNT = 8,
  parameter int CAS_LATENCY = 2,
  parameter int BURST_LEN = 1,
  parameter int BURST_TYPE = 0,
  parameter int WRITE_BURST_SINGLE = 1
) (
  input  logic              iclk,
  input  logic              ireset_n,
  sdram_init_seq_if.slave   ctl,
  output logic              DRAM_CLK,
  output logic              DRAM_CKE,
  output logic [ADDR_W-1:0] DRAM_ADDR,
  output logic [BA_W-1:0]   DRAM_BA,
  output logic              DRAM_CS_N,
  output logic              DRAM_RAS_N,
  output logic              DRAM_CAS_N,
  output logic              DRAM_WE_N,
  output logic              DRAM_LDQM,
  output logic              DRAM_UDQM,
  output logic [DQ_W-1:0]   DRAM_DQ
);
  if (!(BURST_LEN == 1 || BURST_LEN == 2 || BURST_LEN == 4 || BURST_LEN == 8 || BURST_LEN == 512)) begin : g_bad_burst
    $error("sdram_init_seq: unsupported BURST_LEN %0d", BURST_LEN);
  end
  localparam int T_A = T_POWERUP > T_RP ? T_POWERUP : T_RP;
  localparam int T_B = T_RFC > T_MRD ? T_RFC : T_MRD;
  localparam int T_C = T_A > T_B ? T_A : T_B;
  localparam int TMAX = T_C > REFRESH_COUNT ? T_C : REFRESH_COUNT;
  localparam int CW = $clog2(TMAX) + 1;
  localparam logic [2:0] BL_CODE = BURST_LEN == 1 ? 3'b000 : BURST_LEN == 2 ? 3'b001 :
                                   BURST_LEN == 4 ? 3'b010 : BURST_LEN == 8 ? 3'b011 : 3'b111;
  localparam logic [ADDR_W-1:0] MODE = ADDR_W'({1'(WRITE_BURST_SINGLE), 2'b00, 3'(CAS_LATENCY), 1'(BURST_TYPE), BL_CODE});
  localparam logic [ADDR_W-1:0] PRE_A = ADDR_W'(1024);
  localparam logic [3:0] C_NOP = 4'b0111, C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;
  // Wait phases after a command last T-1 cycles, so the reload is T-2 and a T of 1 skips the phase
  localparam logic [CW-1:0] L_PWR = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] L_RP = CW'(T_RP > 1 ? T_RP - 2 : 0);
  localparam logic [CW-1:0] L_RFC = CW'(T_RFC > 1 ? T_RFC - 2 : 0);
  localparam logic [CW-1:0] L_MRD = CW'(T_MRD > 1 ? T_MRD - 2 : 0);
  localparam logic [CW-1:0] N_REF = CW'(REFRESH_COUNT);
  typedef enum logic [3:0] {IDLE, PWR_WAIT, PRE, RP_WAIT, REF, RFC_WAIT, MRS, MRD_WAIT, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_n, rcnt, rcnt_n;
  logic [3:0] cmd;
  logic [ADDR_W-1:0] addr;
  logic cke, busy, fin;
  always_comb begin
    nxt = state;
    cnt_n = cnt == '0 ? '0 : cnt - 1'b1;
    rcnt_n = rcnt;
    unique case (state)
      IDLE: if (ctl.ireq) begin
        nxt = PWR_WAIT;
        cnt_n = L_PWR;
      end
      PWR_WAIT: nxt = cnt == '0 ? PRE : PWR_WAIT;
      PRE: begin
        rcnt_n = '0;
        nxt = T_RP > 1 ? RP_WAIT : REF;
        cnt_n = L_RP;
      end
      RP_WAIT: nxt = cnt == '0 ? REF : RP_WAIT;
      REF: begin
        rcnt_n = rcnt + 1'b1;
        nxt = T_RFC > 1 ? RFC_WAIT : rcnt_n < N_REF ? REF : MRS;
        cnt_n = L_RFC;
      end
      RFC_WAIT: nxt = cnt != '0 ? RFC_WAIT : rcnt < N_REF ? REF : MRS;
      MRS: begin
        nxt = T_MRD > 1 ? MRD_WAIT : DONE;
        cnt_n = L_MRD;
      end
      MRD_WAIT: nxt = cnt == '0 ? DONE : MRD_WAIT;
      DONE: nxt = ctl.ireq ? PRE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge iclk or negedge ireset_n)
    if (!ireset_n) begin
      state <= IDLE;
      cnt <= '0;
      rcnt <= '0;
      cmd <= C_NOP;
      addr <= '0;
      cke <= 1'b0;
      busy <= 1'b0;
      fin <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      rcnt <= rcnt_n;
      cmd <= state == PRE ? C_PRE : state == REF ? C_REF : state == MRS ? C_MRS : C_NOP;
      addr <= state == PRE ? PRE_A : state == MRS ? MODE : '0;
      cke <= state != IDLE;
      busy <= state != IDLE && state != DONE;
      fin <= state == DONE;
    end
  assign ctl.obusy = busy;
  assign ctl.ofin = fin;
  assign DRAM_CLK = ctl.ienb ? iclk : 1'bz;
  assign DRAM_CKE = ctl.ienb ? cke : 1'bz;
  assign DRAM_ADDR = ctl.ienb ? addr : {ADDR_W{1'bz}};
  assign DRAM_BA = ctl.ienb ? '0 : {BA_W{1'bz}};
  assign DRAM_CS_N = ctl.ienb ? cmd[3] : 1'bz;
  assign DRAM_RAS_N = ctl.ienb ? cmd[2] : 1'bz;
  assign DRAM_CAS_N = ctl.ienb ? cmd[1] : 1'bz;
  assign DRAM_WE_N = ctl.ienb ? cmd[0] : 1'bz;
  assign DRAM_LDQM = ctl.ienb ? 1'b1 : 1'bz;
  assign DRAM_UDQM = ctl.ienb ? 1'b1 : 1'bz;
  assign DRAM_DQ = ctl.ienb ? '0 : {DQ_W{1'bz}};
endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq: directed checks of init timing, mode word, re-init, async reset and bus release
module tb_sdram_init_seq;
  logic iclk = 1'b0, ireset_n = 1'b0;
  int total = 0, bad = 0;
  always #5 iclk = ~iclk;
  sdram_init_seq_if ia(), ib(), ic(), id();
  wire a_clk, a_cke, a_cs, a_ras, a_cas, a_we, a_ldqm, a_udqm;
  wire b_clk, b_cke, b_cs, b_ras, b_cas, b_we, b_ldqm, b_udqm;
  wire c_clk, c_cke, c_cs, c_ras, c_cas, c_we, c_ldqm, c_udqm;
  wire d_clk, d_cke, d_cs, d_ras, d_cas, d_we, d_ldqm, d_udqm;
  wire [12:0] a_addr, b_addr, c_addr, d_addr;
  wire [1:0] a_ba, b_ba, c_ba, d_ba;
  wire [15:0] a_dq, b_dq, c_dq, d_dq;
  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;
  sdram_init_seq #(.T_POWERUP(4), .T_RP(3), .T_RFC(7), .T_MRD(2), .REFRESH_COUNT(2)) dut_a (
    .iclk(iclk), .ireset_n(ireset_n), .ctl(ia), .DRAM_CLK(a_clk), .DRAM_CKE(a_cke), .DRAM_ADDR(a_addr),
    .DRAM_BA(a_ba), .DRAM_CS_N(a_cs), .DRAM_RAS_N(a_ras), .DRAM_CAS_N(a_cas), .DRAM_WE_N(a_we),
    .DRAM_LDQM(a_ldqm), .DRAM_UDQM(a_udqm), .DRAM_DQ(a_dq));
  sdram_init_seq #(.T_POWERUP(1), .T_RP(1), .T_RFC(1), .T_MRD(1), .REFRESH_COUNT(1), .CAS_LATENCY(3),
                   .BURST_LEN(8), .BURST_TYPE(1), .WRITE_BURST_SINGLE(0)) dut_b (
    .iclk(iclk), .ireset_n(ireset_n), .ctl(ib), .DRAM_CLK(b_clk), .DRAM_CKE(b_cke), .DRAM_ADDR(b_addr),
    .DRAM_BA(b_ba), .DRAM_CS_N(b_cs), .DRAM_RAS_N(b_ras), .DRAM_CAS_N(b_cas), .DRAM_WE_N(b_we),
    .DRAM_LDQM(b_ldqm), .DRAM_UDQM(b_udqm), .DRAM_DQ(b_dq));
  sdram_init_seq #(.T_POWERUP(1), .T_RP(1), .T_RFC(1), .T_MRD(1), .REFRESH_COUNT(1), .BURST_LEN(512)) dut_c (
    .iclk(iclk), .ireset_n(ireset_n), .ctl(ic), .DRAM_CLK(c_clk), .DRAM_CKE(c_cke), .DRAM_ADDR(c_addr),
    .DRAM_BA(c_ba), .DRAM_CS_N(c_cs), .DRAM_RAS_N(c_ras), .DRAM_CAS_N(c_cas), .DRAM_WE_N(c_we),
    .DRAM_LDQM(c_ldqm), .DRAM_UDQM(c_udqm), .DRAM_DQ(c_dq));
  sdram_init_seq #(.T_POWERUP(2), .T_RP(1), .T_RFC(1), .T_MRD(1), .REFRESH_COUNT(1)) dut_d (
    .iclk(iclk), .ireset_n(ireset_n), .ctl(id), .DRAM_CLK(d_clk), .DRAM_CKE(d_cke), .DRAM_ADDR(d_addr),
    .DRAM_BA(d_ba), .DRAM_CS_N(d_cs), .DRAM_RAS_N(d_ras), .DRAM_CAS_N(d_cas), .DRAM_WE_N(d_we),
    .DRAM_LDQM(d_ldqm), .DRAM_UDQM(d_udqm), .DRAM_DQ(d_dq));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic hz(input logic v);
    return v === 1'bz || v === 1'b0;
  endfunction
  task automatic chk_a_reset(input string tag);
    chk({tag, "_cke"}, a_cke, 0);
    chk({tag, "_cmd"}, {a_cs, a_ras, a_cas, a_we}, NOP);
    chk({tag, "_addr"}, a_addr, 0);
    chk({tag, "_fin"}, ia.ofin, 0);
    chk({tag, "_busy"}, ia.obusy, 0);
  endtask
  // ireq accepted at edge 0; cycle k is sampled 1 time unit after edge k
  task automatic run_a(input int last);
    logic [3:0] ea, ed;
    ia.ireq = 1'b1; ib.ireq = 1'b1; ic.ireq = 1'b1; id.ireq = 1'b1;
    @(posedge iclk); #1;
    ia.ireq = 1'b0; ib.ireq = 1'b0; ic.ireq = 1'b0; id.ireq = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(posedge iclk); #1;
      ea = k == 5 ? PRE : (k == 8 || k == 15) ? REF : k == 22 ? MRS : NOP;
      ed = k == 3 ? PRE : k == 4 ? REF : k == 5 ? MRS : NOP;
      chk($sformatf("a_cmd@%0d", k), {a_cs, a_ras, a_cas, a_we}, ea);
      chk($sformatf("a_addr@%0d", k), a_addr, k == 5 ? 32'h400 : k == 22 ? 32'h220 : 0);
      chk($sformatf("a_cke@%0d", k), a_cke, 1);
      chk($sformatf("a_fin@%0d", k), ia.ofin, k >= 24);
      chk($sformatf("a_busy@%0d", k), ia.obusy, k < 24);
      chk($sformatf("d_cmd@%0d", k), {d_cs, d_ras, d_cas, d_we}, ed);
      chk($sformatf("d_fin@%0d", k), id.ofin, k >= 6);
      if (k == 4) begin
        chk("b_mode", b_addr, 32'h03B);
        chk("b_cmd_mrs", {b_cs, b_ras, b_cas, b_we}, MRS);
        chk("c_mode", c_addr, 32'h227);
      end
      if (k == 5) chk("b_fin", ib.ofin, 1);
    end
  endtask
  // re-init from DONE; with enb=0 the command bus must float while the sequence still advances
  task automatic reinit_a(input logic enb);
    logic [3:0] ea;
    ia.ireq = 1'b1;
    ia.ienb = enb;
    @(posedge iclk); #1;
    ia.ireq = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge iclk); #1;
      ea = j == 1 ? PRE : (j == 4 || j == 11) ? REF : j == 18 ? MRS : NOP;
      if (enb) begin
        chk($sformatf("re_cmd@%0d", j), {a_cs, a_ras, a_cas, a_we}, ea);
        chk($sformatf("re_cke@%0d", j), a_cke, 1);
      end else begin
        chk($sformatf("hiz_ctl@%0d", j), hz(a_cke) && hz(a_cs) && hz(a_ras) && hz(a_cas) && hz(a_we)
            && hz(a_ldqm) && hz(a_udqm), 1);
        chk($sformatf("hiz_addr@%0d", j), a_addr === 13'bz || a_addr === 13'b0, 1);
      end
      chk($sformatf("re_fin@%0d enb=%0d", j, enb), ia.ofin, j == 20);
      if (j == 1) chk("re_busy", ia.obusy, 1);
      if (j == 1 && enb) chk("re_addr_pre", a_addr, 32'h400);
    end
  endtask
  initial begin
    ia.ireq = 1'b0; ib.ireq = 1'b0; ic.ireq = 1'b0; id.ireq = 1'b0;
    ia.ienb = 1'b1; ib.ienb = 1'b1; ic.ienb = 1'b1; id.ienb = 1'b1;
    #12;
    chk_a_reset("rst");
    chk("rst_ba", a_ba, 0);
    chk("rst_dqm", {a_ldqm, a_udqm}, 2'b11);
    chk("rst_dq", a_dq, 0);
    @(negedge iclk);
    ireset_n = 1'b1;
    @(posedge iclk); #1;
    chk("idle_cke", a_cke, 0);
    run_a(16);
    ireset_n = 1'b0;
    #1;
    chk_a_reset("async_rst");
    @(negedge iclk);
    @(negedge iclk);
    ireset_n = 1'b1;
    run_a(26);
    reinit_a(1'b1);
    reinit_a(1'b0);
    ia.ienb = 1'b1;
    #1;
    chk("enb_back_cke", a_cke, 1);
    chk("enb_back_cmd", {a_cs, a_ras, a_cas, a_we}, NOP);
    chk("enb_back_dqm", {a_ldqm, a_udqm}, 2'b11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_init_seq.md
Name: sdram_init_seq

Overview:
Parametrised SDRAM power-up and initialisation sequencer, the successor to the fixed init block. Sequence is CKE assertion, power-up NOP wait, PRECHARGE ALL, N x AUTO REFRESH, then LOAD MODE REGISTER. Waits between commands and the mode-register word are derived from parameters. Drives the shared DRAM command bus only while ienb=1, and can re-run the sequence (without the power-up wait) on request after completion.

Parameters:
ADDR_W, 13, DRAM address width (>=11)
BA_W, 2, bank address width
DQ_W, 16, data bus width
T_POWERUP, 10000, NOP cycles after CKE rise before PRECHARGE (>=1)
T_RP, 3, cycles from PRECHARGE to next command (>=1)
T_RFC, 7, cycles from REFRESH to next command (>=1)
T_MRD, 2, cycles from LOAD MODE to ofin rising (>=1)
REFRESH_COUNT, 8, number of AUTO REFRESH commands (>=1)
CAS_LATENCY, 2, 2 or 3
BURST_LEN, 1, one of 1, 2, 4, 8, 512 (full page); any other value fails elaboration
BURST_TYPE, 0, 0 = sequential, 1 = interleaved
WRITE_BURST_SINGLE, 1, 1 = single-location write, 0 = programmed burst

Ports:
iclk  in  1  system clock; also forwarded to DRAM_CLK
ireset_n  in  1  asynchronous active-low reset
ireq  in  1  start request; level sampled in IDLE and DONE only
ienb  in  1  bus ownership; 0 puts every DRAM_* output in high-Z
obusy  out  1  high from the cycle after ireq is accepted until ofin rises
ofin  out  1  initialisation complete
DRAM_CLK  out  1  = iclk when ienb, else Z
DRAM_CKE  out  1  clock enable
DRAM_ADDR  out  ADDR_W  address / mode word
DRAM_BA  out  BA_W  bank address
DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  out  1 each  command
DRAM_LDQM, DRAM_UDQM  out  1 each  byte masks
DRAM_DQ  out  DQ_W  driven all-zero when ienb, else Z

Behaviour:
- Command encodings {CS,RAS,CAS,WE}: NOP=0111, PRE=0010, REF=0001, MRS=0000.
- All outputs are registered; ienb only gates the tristate.
- Reset (async, ireset_n=0):
  - state=IDLE, command=NOP, ADDR=0, BA=0, DQM=11, CKE=0.
  - ofin=0, obusy=0, counters=0.
  - Reset asserted mid-sequence aborts immediately with the same values.
- States: IDLE, PWR_WAIT, PRE, RP_WAIT, REF, RFC_WAIT, MRS, MRD_WAIT, DONE.
- IDLE: NOP. ireq=1 -> PWR_WAIT; CKE=1 and obusy=1 from that cycle onward.
- PWR_WAIT: NOP for exactly T_POWERUP cycles -> PRE.
- PRE: one cycle, ADDR[10]=1, other ADDR bits=0, BA=0.
- RP_WAIT: NOP for T_RP-1 cycles (0 cycles if T_RP=1) -> REF.
- REF: one cycle; increments the refresh counter.
- RFC_WAIT: NOP for T_RFC-1 cycles.
  - Exits to REF if count < REFRESH_COUNT, else to MRS.
- MRS: one cycle, BA=0, ADDR = mode word:
  - [2:0] BL code: 1=000, 2=001, 4=010, 8=011, 512=111.
  - [3] BURST_TYPE.
  - [6:4] CAS_LATENCY.
  - [8:7] 00.
  - [9] WRITE_BURST_SINGLE.
  - upper bits 0.
  - Defaults give 13'h0220.
- MRD_WAIT: NOP for T_MRD-1 cycles -> DONE.
- DONE: NOP; ofin=1, obusy=0.
  - ireq=1 -> PRE next cycle; ofin falls in that same cycle, obusy rises, CKE stays 1 (re-init without power-up wait).
- Command-to-command spacing equals exactly T_RP / T_RFC / T_MRD cycles.
- Latency from accepting ireq to ofin rising: 1 + T_POWERUP + T_RP + REFRESH_COUNT*T_RFC + T_MRD.
- Re-init latency from DONE: 1 + T_RP + REFRESH_COUNT*T_RFC + T_MRD.
- ireq is ignored in all states except IDLE and DONE; no queuing.
- DQM=11 in all states.
- Counter width is $clog2 of the largest timing parameter plus 1; counters never wrap within a phase.
- The wait counter reloads on every state entry.

Test Plan:
- Overrides T_POWERUP=4, T_RP=3, T_RFC=7, T_MRD=2, REFRESH_COUNT=2, ireq pulsed at edge 0 -> CKE=1 from cycle 1; PRE at cycle 5 with ADDR=0x400; REF at 8 and 15; MRS at 22 with ADDR=0x220; ofin=1 at 24; NOP on all other cycles.
- From DONE in that run, ireq for 1 cycle -> PRE next cycle with ofin=0 and obusy=1; ofin returns 1 exactly 20 cycles after PRE-1 (1+3+14+2); CKE never drops.
- CAS_LATENCY=3, BURST_LEN=8, BURST_TYPE=1, WRITE_BURST_SINGLE=0 -> MRS ADDR=0x03B; BURST_LEN=512 -> ADDR[2:0]=111.
- ireset_n driven low at cycle 16 of the first scenario -> outputs return to reset values asynchronously (CKE=0, ofin=0, NOP); after release plus ireq, the full sequence repeats with the same timing.
- ienb=0 during the sequence -> every DRAM_* output is Z while state still advances; ofin rises at the same cycle as with ienb=1.
- T_RP=T_RFC=T_MRD=1, REFRESH_COUNT=1 -> PRE, REF, MRS on consecutive cycles; ofin on the following cycle.
